// File: rtl/seq_det_prm_if.sv
// Serial pattern detector bus.
// Config, serial data and counter signals.
interface seq_det_prm_if #(
  parameter int N  = 8,
  parameter int LW = 5,
  parameter int CW = 8
);
  logic          cfg_ld;
  logic [N-1:0]  pat;
  logic [LW-1:0] len;
  logic          ovl;
  logic          en;
  logic          x;
  logic          clr;
  logic          y;
  logic [CW-1:0] cnt;
  logic          sat;

  modport master (
    output cfg_ld, pat, len, ovl,
    output en, x, clr,
    input  y, cnt, sat
  );

  modport slave (
    input  cfg_ld, pat, len, ovl,
    input  en, x, clr,
    output y, cnt, sat
  );
endinterface

// File: rtl/seq_det_prm.sv
// Programmable serial bit-pattern detector
// with saturating hit counter.
module seq_det_prm #(
  parameter int N  = 8,
  parameter int LW = 5,
  parameter int CW = 8
) (
  input logic          clk,
  input logic          reset,
  seq_det_prm_if.slave bus
);

  logic [N-1:0]  pat_r;
  logic [LW-1:0] len_r;
  logic          ovl_r;
  logic [N-1:0]  h_q;
  logic [LW-1:0] fill_q;
  logic          y_q;
  logic [CW-1:0] cnt_q;
  logic          sat_q;

  logic [LW-1:0] len_c;
  logic [N-1:0]  h_nx;
  logic [LW-1:0] fill_nx;
  logic [N-1:0]  mask;
  logic          match;
  logic          hit;
  logic [CW-1:0] cnt_nx;

  // Clamp requested length and build next history/fill
  always_comb begin
    len_c = bus.len;
    if (bus.len > LW'(N))
      len_c = LW'(N);
    h_nx = {h_q[N-2:0], bus.x};
    fill_nx = fill_q;
    if (fill_q != LW'(N))
      fill_nx = fill_q + LW'(1);
  end

  // Compare only the low len_r bits, gated by fill
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++)
      mask[i] = (LW'(i) < len_r);
    match = (len_r != '0)
         && (fill_nx >= len_r)
         && (((h_nx ^ pat_r) & mask) == '0);
  end

  assign hit    = !bus.cfg_ld && bus.en && match;
  assign cnt_nx = cnt_q + CW'(1);

  // Config latch, history shift and hit pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_r  <= '0;
      len_r  <= '0;
      ovl_r  <= 1'b1;
      h_q    <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
    end else if (bus.cfg_ld) begin
      pat_r  <= bus.pat;
      len_r  <= len_c;
      ovl_r  <= bus.ovl;
      h_q    <= '0;
      fill_q <= '0;
      y_q    <= 1'b0;
    end else if (bus.en) begin
      h_q <= h_nx;
      if (match && !ovl_r)
        fill_q <= '0;
      else
        fill_q <= fill_nx;
      y_q <= match;
    end else begin
      y_q <= 1'b0;
    end
  end

  // Saturating hit counter; clear beats a hit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (bus.clr) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (hit && !sat_q) begin
      cnt_q <= cnt_nx;
      sat_q <= &cnt_nx;
    end
  end

  assign bus.y   = y_q;
  assign bus.cnt = cnt_q;
  assign bus.sat = sat_q;

endmodule

// File: tb/tb_seq_det_prm.sv
// Scoreboard bench for seq_det_prm.
// Queue-based reference model, random + directed.
module tb_seq_det_prm;

  localparam int N  = 8;
  localparam int LW = 5;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk;
  logic reset;

  seq_det_prm_if #(.N(N), .LW(LW), .CW(CW)) bus ();

  seq_det_prm #(.N(N), .LW(LW), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          y;
    logic [CW-1:0] cnt;
    logic          sat;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // reference model state
  bit   hist[$];
  logic [N-1:0] mp;
  int   ml;
  bit   mo;
  int   mc;

  function automatic bit m_match();
    int sz;
    sz = hist.size();
    if (ml == 0 || sz < ml) return 1'b0;
    for (int i = 0; i < ml; i++)
      if (hist[sz - ml + i] != mp[ml - 1 - i])
        return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    hist.delete();
    mp = '0;
    ml = 0;
    mo = 1'b1;
    mc = 0;
  endtask

  task automatic chk(
    input string nm,
    input int act,
    input int req
  );
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d",
               nm, act, req);
    end
  endtask

  // one clock of stimulus + model step
  task automatic cyc(
    input logic        c_ld,
    input logic [N-1:0] p,
    input logic [LW-1:0] l,
    input logic        o,
    input logic        e,
    input logic        xb,
    input logic        c
  );
    exp_t ex;
    bit hit;
    @(negedge clk);
    bus.cfg_ld = c_ld;
    bus.pat    = p;
    bus.len    = l;
    bus.ovl    = o;
    bus.en     = e;
    bus.x      = xb;
    bus.clr    = c;
    hit = 1'b0;
    if (c_ld) begin
      mp = p;
      ml = (int'(l) > N) ? N : int'(l);
      mo = o;
      hist.delete();
    end else if (e) begin
      hist.push_back(xb);
      if (hist.size() > N) void'(hist.pop_front());
      hit = m_match();
      if (hit && !mo) hist.delete();
    end
    if (c) mc = 0;
    else if (hit && mc < CMAX) mc++;
    ex.y   = hit;
    ex.cnt = CW'(mc);
    ex.sat = (mc == CMAX);
    exp_q.push_back(ex);
  endtask

  task automatic bit_in(input logic xb);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, xb, 1'b0);
  endtask

  task automatic idle(input logic xb);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, xb, 1'b0);
  endtask

  task automatic cfg(
    input logic [N-1:0] p,
    input logic [LW-1:0] l,
    input logic o
  );
    cyc(1'b1, p, l, o, 1'b1, 1'b1, 1'b1);
  endtask

  // value right after the last issued edge
  task automatic after_edge(
    input string nm,
    input int y_req,
    input int c_req
  );
    @(posedge clk);
    #2;
    chk({nm, "_y"}, int'(bus.y), y_req);
    chk({nm, "_cnt"}, int'(bus.cnt), c_req);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 10) begin
      @(posedge clk);
      k++;
    end
    #3;
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_reset(input string nm);
    drain();
    @(negedge clk);
    bus.cfg_ld = 1'b0;
    bus.en     = 1'b0;
    bus.clr    = 1'b0;
    reset = 1'b0;
    m_reset();
    #1;
    chk({nm, "_y"}, int'(bus.y), 0);
    chk({nm, "_cnt"}, int'(bus.cnt), 0);
    chk({nm, "_sat"}, int'(bus.sat), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // monitor: compare DUT outputs to the oldest expectation
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (bus.y !== e.y || bus.cnt !== e.cnt
          || bus.sat !== e.sat) begin
        bad++;
        $display("FAIL scoreboard t=%0t y/cnt/sat actual=%0b/%0d/%0b required=%0b/%0d/%0b",
                 $time, bus.y, bus.cnt, bus.sat,
                 e.y, e.cnt, e.sat);
      end
    end
  end

  logic [7:0] a5;

  initial begin
    reset      = 1'b0;
    bus.cfg_ld = 1'b0;
    bus.pat    = '0;
    bus.len    = '0;
    bus.ovl    = 1'b0;
    bus.en     = 1'b0;
    bus.x      = 1'b0;
    bus.clr    = 1'b0;
    m_reset();
    #12;
    chk("rst_y", int'(bus.y), 0);
    chk("rst_cnt", int'(bus.cnt), 0);
    chk("rst_sat", int'(bus.sat), 0);
    @(negedge clk);
    reset = 1'b1;

    // detection disabled out of reset
    for (int i = 0; i < 6; i++) bit_in(1'b1);
    after_edge("rst_disabled", 0, 0);

    // legacy 001
    cfg(8'b001, 5'd3, 1'b1);
    bit_in(0); bit_in(0); bit_in(1);
    after_edge("legacy_hit1", 1, 1);
    bit_in(0); bit_in(0); bit_in(1);
    after_edge("legacy_hit2", 1, 2);

    // overlap 1010
    cfg(8'b1010, 5'd4, 1'b1);
    bit_in(1); bit_in(0); bit_in(1); bit_in(0);
    bit_in(1); bit_in(0);
    after_edge("ovl1", 1, 2);
    cfg(8'b1010, 5'd4, 1'b0);
    bit_in(1); bit_in(0); bit_in(1); bit_in(0);
    bit_in(1); bit_in(0);
    after_edge("ovl0", 0, 1);

    // back-to-back 11
    cfg(8'b11, 5'd2, 1'b1);
    bit_in(1); bit_in(1);
    after_edge("b2b_1", 1, 1);
    bit_in(1);
    after_edge("b2b_2", 1, 2);

    // fill gating and en hold
    cfg(8'b000, 5'd3, 1'b1);
    bit_in(0); bit_in(0);
    after_edge("fill_gate", 0, 0);
    for (int i = 0; i < 5; i++) idle(1'(i));
    bit_in(0);
    after_edge("en_hold", 1, 1);

    // saturation and clear
    cfg(8'b1, 5'd1, 1'b1);
    for (int i = 0; i < 5; i++) bit_in(1);
    after_edge("sat_cnt", 1, CMAX);
    chk("sat_flag", int'(bus.sat), 1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
    after_edge("clr_hit", 1, 0);
    chk("clr_sat", int'(bus.sat), 0);

    // len 0 disables
    cfg(8'hFF, 5'd0, 1'b1);
    for (int i = 0; i < 20; i++)
      bit_in(1'($urandom_range(0, 1)));
    after_edge("len0", 0, 0);

    // len clamp
    cfg(8'hA5, 5'd31, 1'b1);
    a5 = 8'hA5;
    for (int i = 7; i >= 0; i--) bit_in(a5[i]);
    after_edge("clamp", 1, 1);

    // reset mid-pattern
    cfg(8'b011, 5'd3, 1'b1);
    bit_in(0); bit_in(1);
    do_reset("mid_rst");
    bit_in(0); bit_in(1); bit_in(1);
    after_edge("post_rst", 0, 0);
    cfg(8'b011, 5'd3, 1'b1);
    bit_in(0); bit_in(1); bit_in(1);
    after_edge("post_cfg", 1, 1);

    // randomized run
    for (int n = 0; n < 1500; n++) begin
      logic ld, o, e, xb, c;
      logic [N-1:0] p;
      logic [LW-1:0] l;
      ld = ($urandom_range(0, 19) == 0);
      p  = N'($urandom);
      if ($urandom_range(0, 3) == 0)
        l = LW'($urandom_range(0, 31));
      else
        l = LW'($urandom_range(1, 4));
      o  = 1'($urandom_range(0, 1));
      e  = ($urandom_range(0, 3) != 0);
      xb = 1'($urandom_range(0, 1));
      c  = ($urandom_range(0, 15) == 0);
      cyc(ld, p, l, o, e, xb, c);
      if (n == 700) do_reset("rand_rst");
    end

    idle(1'b0);
    drain();
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
